goe_egress_dmux: RTL and testbench
==================================

Name: goe_egress_dmux

Overview:
- Egress stage directly downstream of goe.
- Accepts goe's 134-bit packet stream and per-packet valid flag, buffers whole packets, and steers each one to one of 4 output ports.
- Port selection comes from a 2-bit destination field in the header word.
- Drops packets flagged invalid or addressed to a disabled port.
- Provides the pktout_ready backpressure that goe samples before it starts each packet.

Parameters:
- DATA_DEPTH, 256: data FIFO depth in 134-bit words (power of 2).
- VALID_DEPTH, 64: valid-flag FIFO depth in entries.
- MAX_PKT_WORDS, 32: largest packet in words; sets the ready threshold.
- DPORT_LSB, 88: bit position of the 2-bit destination port field in the header word.
- PORT_EN, 4'b1111: bitmap of enabled output ports.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- pktout_data_wr, in, 1: input word strobe.
- pktout_data, in, 134: input word; [133:132]=01 header, 10 tail, 11 body.
- pktout_data_valid_wr, in, 1: per-packet flag strobe; coincides with the tail word or follows it.
- pktout_data_valid, in, 1: 1 = forward packet, 0 = drop packet.
- pktout_ready, out, 1: room for one maximum-size packet is available.
- out_port_data_wr, out, 4: one-hot word strobe per port.
- out_port_data, out, 134: data bus shared by all ports.
- out_port_valid_wr, out, 4: one-hot end-of-packet strobe.
- out_port_valid, out, 1: always 1 when any out_port_valid_wr bit is set.
- in_port_alf, in, 4: per-port almost-full.
- out_tx_cnt, out, 32: count of forwarded packets.
- out_drop_cnt, out, 32: count of dropped packets.
- out_ovf, out, 1: sticky flag, set when a word or flag is written while its FIFO is full.

Behaviour:
- Reset: every output is 0 except pktout_ready, which is 1 from the first cycle after reset. Both FIFOs are emptied, counters cleared, FSMs go to IDLE.
- Reset mid-packet: the partial packet is lost.

Ingress:
- A 1-bit ingress FSM, ING_IDLE / ING_PKT, gates writes.
- In ING_IDLE, words are accepted only when they are headers. Non-header words are silently discarded; this resyncs the stream after a reset.
- In ING_PKT, every word is written to the data FIFO. A tail word returns the FSM to ING_IDLE.
- The valid FIFO is written on every pktout_data_valid_wr, independent of the ingress FSM.
- pktout_ready is registered: 1 when data_usedw <= DATA_DEPTH-MAX_PKT_WORDS and valid_usedw < VALID_DEPTH-1.
- A write to a full FIFO is dropped and sets out_ovf. out_ovf clears only on rst.

Egress FSM: states E_IDLE, E_WAIT, E_SEND, E_DROP. Both FIFOs are first-word-fall-through.
- E_IDLE:
  - Condition: valid FIFO not empty and data FIFO not empty.
  - Latch dport = head[DPORT_LSB+1:DPORT_LSB] and pop the valid FIFO.
  - If the flag is 0 or PORT_EN[dport] is 0, go to E_DROP; otherwise go to E_WAIT.
  - If the data FIFO head is not a header, drop it with a single pop and stay in E_IDLE.
- E_WAIT: when in_port_alf[dport] is 0, go to E_SEND; otherwise hold with no pops.
- E_SEND:
  - Every cycle: pop one word, out_port_data = word, out_port_data_wr[dport] = 1.
  - Packets are never paused once started; in_port_alf is checked only in E_WAIT.
  - On the tail word, out_port_valid_wr[dport] = 1 and out_port_valid = 1 in the same cycle, out_tx_cnt increments, and the FSM returns to E_IDLE.
- E_DROP: pop one word per cycle with no outputs. On the tail word, out_drop_cnt increments and the FSM returns to E_IDLE.
- Outputs are registered and held at 0 when not driven.

Timing:
- Latency: a header visible in E_IDLE with alf low appears on out_port_data 2 cycles later.
- Back-to-back packets have at least 1 idle cycle between them.
- A simultaneous FIFO write and pop is legal; usedw is unchanged.
- Both counters wrap modulo 2^32.

Decomposition:
- Package goe_pkg holds:
  - Header-type constants: HDR=2'b01, TAIL=2'b10, BODY=2'b11.
  - Field LSBs: DPORT_LSB default, WORD_W=134.
  - Egress state encodings: E_IDLE=0, E_WAIT=1, E_SEND=2, E_DROP=3.
- Sub-module goe_sfifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH. Ports: wr, din, rd, dout, empty, full, usedw. It is instantiated twice, once 134 wide and once 1 wide.

Test Plan:
1. 4-word packet (hdr dport=2, body, body, tail) with valid=1, all alf=0 -> 4 beats with out_port_data_wr=4'b0100. valid_wr[2] is asserted on the tail. out_tx_cnt=1. Header appears 2 cycles after the egress FSM first sees it.
2. Same packet with valid=0 -> no out_port_* activity, out_drop_cnt=1, both FIFOs empty afterwards.
3. dport=3 with PORT_EN=4'b0111 -> packet dropped, out_drop_cnt=1.
4. in_port_alf[1]=1 held 10 cycles while a dport=1 packet is queued -> no beats. Release alf -> first beat 1 cycle after release, and the full packet is sent without gaps.
5. Stream 8 packets of 32 words with out_port_data_wr/egress stalled -> pktout_ready drops once usedw > 224. Stalled packets all eventually exit, out_ovf=0.
6. Assert rst while word 2 of a packet is being written, then send its remaining body/tail plus one new packet -> the stray words are discarded, only the new packet is forwarded, out_tx_cnt=1.

Source files
------------

// File: rtl/goe_pkg.sv
// Shared definitions for the goe egress path: word types, field positions, FSM encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package goe_pkg;

    localparam int WORD_W        = 134;
    localparam int DPORT_LSB_DEF = 88;

    // Word type lives in the top two bits of every 134-bit word.
    localparam logic [1:0] HDR  = 2'b01;
    localparam logic [1:0] TAIL = 2'b10;
    localparam logic [1:0] BODY = 2'b11;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_WAIT = 2'd1,
        E_SEND = 2'd2,
        E_DROP = 2'd3
    } egr_state_t;

    typedef enum logic {
        ING_IDLE = 1'b0,
        ING_PKT  = 1'b1
    } ing_state_t;

    function automatic logic [1:0] word_type(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: 2];
    endfunction

endpackage

// File: rtl/goe_sfifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
// Latency: a word written on one edge is visible on dout after that edge.
// Backpressure: writes while full and reads while empty are ignored.
//
// Ports: clk, rst (sync, active-high), wr/din push, rd pop, dout head word,
//        empty, full, usedw (entry count, 0..DEPTH). DEPTH must be a power of 2.
module goe_sfifo #(
    parameter int WIDTH = 134,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   usedw
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (usedw == '0);
    assign full  = (usedw == (AW+1)'(DEPTH));
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of 2.
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: usedw <= usedw;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/goe_egress_dmux.sv
// Buffers whole goe packets and steers each to one of 4 ports by its header dport field.
// Latency: header seen in E_IDLE with alf low appears on out_port_data 2 cycles later.
// Backpressure: pktout_ready drops when a max-size packet no longer fits; a port's alf
//               holds a packet only before its first beat, never mid-packet.
//
// Ports: clk, rst (sync, active-high); pktout_* ingress stream and per-packet flag;
//        pktout_ready; out_port_* one-hot egress strobes and shared data bus;
//        in_port_alf per-port almost-full; out_tx_cnt / out_drop_cnt; out_ovf sticky.
module goe_egress_dmux
    import goe_pkg::*;
#(
    parameter int         DATA_DEPTH    = 256,
    parameter int         VALID_DEPTH   = 64,
    parameter int         MAX_PKT_WORDS = 32,
    parameter int         DPORT_LSB     = DPORT_LSB_DEF,
    parameter logic [3:0] PORT_EN       = 4'b1111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pktout_data_wr,
    input  logic [WORD_W-1:0] pktout_data,
    input  logic              pktout_data_valid_wr,
    input  logic              pktout_data_valid,
    output logic              pktout_ready,
    output logic [3:0]        out_port_data_wr,
    output logic [WORD_W-1:0] out_port_data,
    output logic [3:0]        out_port_valid_wr,
    output logic              out_port_valid,
    input  logic [3:0]        in_port_alf,
    output logic [31:0]       out_tx_cnt,
    output logic [31:0]       out_drop_cnt,
    output logic              out_ovf
);

    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int VAW = $clog2(VALID_DEPTH);

    logic              data_wr_en;
    logic              data_rd;
    logic [WORD_W-1:0] data_dout;
    logic              data_empty;
    logic              data_full;
    logic [DAW:0]      data_usedw;

    logic              valid_rd;
    logic              valid_dout;
    logic              valid_empty;
    logic              valid_full;
    logic [VAW:0]      valid_usedw;

    goe_sfifo #(.WIDTH(WORD_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (data_wr_en),
        .din   (pktout_data),
        .rd    (data_rd),
        .dout  (data_dout),
        .empty (data_empty),
        .full  (data_full),
        .usedw (data_usedw)
    );

    goe_sfifo #(.WIDTH(1), .DEPTH(VALID_DEPTH)) u_valid_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (pktout_data_valid_wr),
        .din   (pktout_data_valid),
        .rd    (valid_rd),
        .dout  (valid_dout),
        .empty (valid_empty),
        .full  (valid_full),
        .usedw (valid_usedw)
    );

    // ---------------- ingress ----------------
    ing_state_t ing_state, ing_next;
    logic [1:0] in_type;

    assign in_type = word_type(pktout_data);

    // Outside a packet only headers get in, which resyncs a stream cut by reset.
    always_comb begin
        ing_next   = ing_state;
        data_wr_en = 1'b0;
        if (pktout_data_wr) begin
            case (ing_state)
                ING_IDLE: begin
                    if (in_type == HDR) begin
                        data_wr_en = 1'b1;
                        ing_next   = ING_PKT;
                    end
                end
                default: begin
                    data_wr_en = 1'b1;
                    if (in_type == TAIL) ing_next = ING_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ing_state    <= ING_IDLE;
            pktout_ready <= 1'b1;
            out_ovf      <= 1'b0;
        end else begin
            ing_state    <= ing_next;
            pktout_ready <= (data_usedw <= (DAW+1)'(DATA_DEPTH - MAX_PKT_WORDS)) &&
                            (valid_usedw < (VAW+1)'(VALID_DEPTH - 1));
            if ((data_wr_en && data_full) || (pktout_data_valid_wr && valid_full))
                out_ovf <= 1'b1;
        end
    end

    // ---------------- egress ----------------
    egr_state_t e_state, e_next;
    logic [1:0] dport;
    logic [1:0] head_dport;
    logic       head_is_hdr;
    logic       head_is_tail;
    logic       latch_dport;
    logic       beat;
    logic       eop;
    logic       drop_done;

    assign head_dport   = data_dout[DPORT_LSB +: 2];
    assign head_is_hdr  = (word_type(data_dout) == HDR);
    assign head_is_tail = (word_type(data_dout) == TAIL);

    always_comb begin
        e_next      = e_state;
        data_rd     = 1'b0;
        valid_rd    = 1'b0;
        latch_dport = 1'b0;
        beat        = 1'b0;
        eop         = 1'b0;
        drop_done   = 1'b0;
        case (e_state)
            E_IDLE: begin
                if (!valid_empty && !data_empty) begin
                    if (head_is_hdr) begin
                        latch_dport = 1'b1;
                        valid_rd    = 1'b1;
                        e_next      = (valid_dout && PORT_EN[head_dport]) ? E_WAIT : E_DROP;
                    end else begin
                        // Orphan word at the head: discard it and look again.
                        data_rd = 1'b1;
                    end
                end
            end
            E_WAIT: begin
                // The header beat is issued on the exit edge so a released alf
                // shows up on the port one cycle later.
                if (!in_port_alf[dport] && !data_empty) begin
                    data_rd = 1'b1;
                    beat    = 1'b1;
                    e_next  = E_SEND;
                end
            end
            E_SEND: begin
                if (!data_empty) begin
                    data_rd = 1'b1;
                    beat    = 1'b1;
                    if (head_is_tail) begin
                        eop    = 1'b1;
                        e_next = E_IDLE;
                    end
                end
            end
            default: begin
                if (!data_empty) begin
                    data_rd = 1'b1;
                    if (head_is_tail) begin
                        drop_done = 1'b1;
                        e_next    = E_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_state <= E_IDLE;
            dport   <= 2'd0;
        end else begin
            e_state <= e_next;
            if (latch_dport) dport <= head_dport;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_port_data_wr  <= '0;
            out_port_data     <= '0;
            out_port_valid_wr <= '0;
            out_port_valid    <= 1'b0;
            out_tx_cnt        <= '0;
            out_drop_cnt      <= '0;
        end else begin
            out_port_data_wr  <= beat ? (4'b0001 << dport) : 4'b0000;
            out_port_data     <= beat ? data_dout : '0;
            out_port_valid_wr <= eop ? (4'b0001 << dport) : 4'b0000;
            out_port_valid    <= eop;
            if (eop)       out_tx_cnt   <= out_tx_cnt + 32'd1;
            if (drop_done) out_drop_cnt <= out_drop_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_goe_egress_dmux.sv
`timescale 1ns/1ps
module tb_goe_egress_dmux;
    import goe_pkg::*;

    localparam logic [3:0] TB_PORT_EN = 4'b0111;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pktout_data_wr = 1'b0;
    logic [133:0] pktout_data = '0;
    logic         pktout_data_valid_wr = 1'b0;
    logic         pktout_data_valid = 1'b0;
    logic         pktout_ready;
    logic [3:0]   out_port_data_wr;
    logic [133:0] out_port_data;
    logic [3:0]   out_port_valid_wr;
    logic         out_port_valid;
    logic [3:0]   in_port_alf = 4'b0000;
    logic [31:0]  out_tx_cnt;
    logic [31:0]  out_drop_cnt;
    logic         out_ovf;

    goe_egress_dmux #(
        .DATA_DEPTH(256), .VALID_DEPTH(64), .MAX_PKT_WORDS(32),
        .DPORT_LSB(88), .PORT_EN(TB_PORT_EN)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .pktout_data_wr       (pktout_data_wr),
        .pktout_data          (pktout_data),
        .pktout_data_valid_wr (pktout_data_valid_wr),
        .pktout_data_valid    (pktout_data_valid),
        .pktout_ready         (pktout_ready),
        .out_port_data_wr     (out_port_data_wr),
        .out_port_data        (out_port_data),
        .out_port_valid_wr    (out_port_valid_wr),
        .out_port_valid       (out_port_valid),
        .in_port_alf          (in_port_alf),
        .out_tx_cnt           (out_tx_cnt),
        .out_drop_cnt         (out_drop_cnt),
        .out_ovf              (out_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    typedef struct packed {
        logic [1:0]   port;
        logic [133:0] word;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    int           exp_tx = 0;
    int           exp_drop = 0;
    logic [133:0] cur_pkt[$];

    int cyc = 0;
    int beats_seen = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = 0;
    int last_tail_cyc = 0;
    bit alf_rand = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (alf_rand)
            for (int p = 0; p < 4; p++) in_port_alf[p] = ($urandom_range(0, 3) == 0);
    end

    function automatic logic [133:0] rnd_word();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[133:0];
    endfunction

    function automatic void build_pkt(input int len, input logic [1:0] dp);
        logic [133:0] w;
        cur_pkt.delete();
        for (int i = 0; i < len; i++) begin
            w = rnd_word();
            w[133:132] = (i == 0) ? HDR : ((i == len - 1) ? TAIL : BODY);
            if (i == 0) w[89:88] = dp;
            cur_pkt.push_back(w);
        end
    endfunction

    // A packet is forwarded iff its flag is set and its port is enabled.
    function automatic void model_accept(input logic flag, input logic [1:0] dp);
        beat_t b;
        if (flag && TB_PORT_EN[dp]) begin
            for (int i = 0; i < cur_pkt.size(); i++) begin
                b.port = dp;
                b.word = cur_pkt[i];
                b.last = (i == cur_pkt.size() - 1);
                exp_q.push_back(b);
            end
            exp_tx++;
        end else begin
            exp_drop++;
        end
    endfunction

    // Egress monitor: every beat must be the next one the model predicts.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && (out_port_data_wr != 4'b0 || out_port_valid_wr != 4'b0)) begin
            if (beats_seen == 0) first_beat_cyc = cyc;
            beats_seen++;
            last_beat_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_val("unexpected_beat", {out_port_data_wr, out_port_valid_wr}, 8'h00);
            end else begin
                e = exp_q.pop_front();
                check_val("beat_port", out_port_data_wr, 4'b0001 << e.port);
                check_val("beat_data", out_port_data, e.word);
                check_val("beat_eop", out_port_valid_wr, e.last ? (4'b0001 << e.port) : 4'b0000);
                check_val("beat_valid", out_port_valid, e.last);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pktout_data_wr = 1'b0;
        pktout_data_valid_wr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_tx = 0;
        exp_drop = 0;
        beats_seen = 0;
    endtask

    task automatic send_pkt(input int len, input logic [1:0] dp, input logic flag,
                            input int flag_delay, input bit wait_ready);
        int t;
        build_pkt(len, dp);
        @(negedge clk);
        if (wait_ready) begin
            t = 0;
            while (!pktout_ready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) check_val("ready_timeout", pktout_ready, 1'b1);
        end
        for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            pktout_data_wr = 1'b1;
            pktout_data = cur_pkt[i];
            if (i == len - 1 && flag_delay == 0) begin
                pktout_data_valid_wr = 1'b1;
                pktout_data_valid = flag;
            end
        end
        @(negedge clk);
        last_tail_cyc = cyc;
        pktout_data_wr = 1'b0;
        pktout_data_valid_wr = 1'b0;
        if (flag_delay > 0) begin
            repeat (flag_delay - 1) @(negedge clk);
            pktout_data_valid_wr = 1'b1;
            pktout_data_valid = flag;
            @(negedge clk);
            pktout_data_valid_wr = 1'b0;
        end
        model_accept(flag, dp);
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) check_val("drain_timeout", exp_q.size(), 0);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int rel_cyc;
        logic [1:0] dp;

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        check_val("rst_data_wr", out_port_data_wr, 4'b0);
        check_val("rst_data", out_port_data, '0);
        check_val("rst_valid_wr", out_port_valid_wr, 4'b0);
        check_val("rst_valid", out_port_valid, 1'b0);
        check_val("rst_tx_cnt", out_tx_cnt, 32'd0);
        check_val("rst_drop_cnt", out_drop_cnt, 32'd0);
        check_val("rst_ovf", out_ovf, 1'b0);
        check_val("rst_ready", pktout_ready, 1'b1);

        // ---- 1: forwarded 4-word packet to port 2 ----
        beats_seen = 0;
        send_pkt(4, 2'd2, 1'b1, 0, 1'b1);
        wait_drain(500);
        check_val("t1_latency", first_beat_cyc - last_tail_cyc, 2);
        check_val("t1_beats", beats_seen, 4);
        check_val("t1_no_gap", last_beat_cyc - first_beat_cyc, 3);
        check_val("t1_tx_cnt", out_tx_cnt, 32'd1);

        // ---- 2: same packet, flag 0 ----
        do_reset();
        send_pkt(4, 2'd2, 1'b0, 0, 1'b1);
        wait_drain(500);
        check_val("t2_beats", beats_seen, 0);
        check_val("t2_drop_cnt", out_drop_cnt, 32'd1);
        check_val("t2_tx_cnt", out_tx_cnt, 32'd0);
        check_val("t2_data_empty", dut.data_empty, 1'b1);
        check_val("t2_valid_empty", dut.valid_empty, 1'b1);

        // ---- 3: disabled port 3 ----
        do_reset();
        send_pkt(5, 2'd3, 1'b1, 1, 1'b1);
        wait_drain(500);
        check_val("t3_beats", beats_seen, 0);
        check_val("t3_drop_cnt", out_drop_cnt, exp_drop);
        check_val("t3_drop_is_one", out_drop_cnt, 32'd1);

        // ---- 4: alf hold then release ----
        do_reset();
        in_port_alf = 4'b0010;
        send_pkt(4, 2'd1, 1'b1, 0, 1'b1);
        repeat (10) @(negedge clk);
        check_val("t4_held", beats_seen, 0);
        in_port_alf = 4'b0000;
        rel_cyc = cyc;
        wait_drain(500);
        check_val("t4_release_lat", first_beat_cyc - rel_cyc, 1);
        check_val("t4_beats", beats_seen, 4);
        check_val("t4_no_gap", last_beat_cyc - first_beat_cyc, 3);
        check_val("t4_tx_cnt", out_tx_cnt, 32'd1);

        // ---- 5: fill with egress stalled ----
        do_reset();
        in_port_alf = 4'b1111;
        for (int k = 0; k < 7; k++) begin
            dp = 2'($urandom_range(0, 2));
            send_pkt(32, dp, 1'b1, 0, 1'b1);
        end
        @(negedge clk);
        check_val("t5_ready_at_224", pktout_ready, 1'b1);
        dp = 2'($urandom_range(0, 2));
        send_pkt(32, dp, 1'b1, 0, 1'b0);
        repeat (2) @(negedge clk);
        check_val("t5_ready_at_256", pktout_ready, 1'b0);
        check_val("t5_stalled", beats_seen, 0);
        in_port_alf = 4'b0000;
        wait_drain(3000);
        check_val("t5_tx_cnt", out_tx_cnt, 32'd8);
        check_val("t5_ovf", out_ovf, 1'b0);
        check_val("t5_ready_after", pktout_ready, 1'b1);

        // ---- 6: reset mid-packet ----
        build_pkt(5, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst = (i == 2);
            pktout_data_wr = 1'b1;
            pktout_data = cur_pkt[i];
        end
        @(negedge clk);
        pktout_data_wr = 1'b0;
        exp_q.delete();
        exp_tx = 0;
        exp_drop = 0;
        beats_seen = 0;
        send_pkt(6, 2'd1, 1'b1, 0, 1'b1);
        wait_drain(500);
        check_val("t6_tx_cnt", out_tx_cnt, 32'd1);
        check_val("t6_drop_cnt", out_drop_cnt, 32'd0);
        check_val("t6_beats", beats_seen, 6);

        // ---- random traffic with random alf ----
        do_reset();
        alf_rand = 1'b1;
        for (int k = 0; k < 30; k++) begin
            send_pkt($urandom_range(2, 32), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) != 0), $urandom_range(0, 2), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain(8000);
        alf_rand = 1'b0;
        in_port_alf = 4'b0000;
        repeat (5) @(negedge clk);
        check_val("rnd_tx_cnt", out_tx_cnt, exp_tx);
        check_val("rnd_drop_cnt", out_drop_cnt, exp_drop);
        check_val("rnd_ovf", out_ovf, 1'b0);
        check_val("rnd_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
